detector_nota: RTL and testbench

- Input stage feeding the modo-1/modo-2 control unit.
- Debounces the piano key inputs and encodes the pressed key into a note code.
- Measures how long the key is held, in metronome ticks.
- On release, registers whether the note and its duration match the expected values from the song memory. Its outputs are the control unit's `nota_feita`, `nota_correta` and `tempo_correto` inputs.

---
 rtl/detector_nota.sv | 175 +++++++++++++++++
 tb/tb_detector_nota.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/detector_nota.sv
// Key input stage: synchronises and debounces the piano keys, encodes the pressed note,
// times the press in metronome ticks and registers note/duration match results on release.
module detector_nota #(
    parameter int NOTAS    = 12,
    parameter int DEBOUNCE = 50000,
    parameter int DUR_W    = 4,
    parameter int TOL      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NOTAS-1:0] botoes,
    input  logic             tick_metro,
    input  logic             zera,
    input  logic [3:0]       nota_esperada,
    input  logic [DUR_W-1:0] duracao_esperada,
    output logic             nota_feita,
    output logic             nota_correta,
    output logic             tempo_correto,
    output logic [3:0]       nota_codigo,
    output logic [DUR_W-1:0] duracao_medida,
    output logic [1:0]       db_estado
);

    localparam logic [1:0] OCIOSO        = 2'd0;
    localparam logic [1:0] PRESSIONADO   = 2'd1;
    localparam logic [1:0] ESPERA_SOLTAR = 2'd2;

    localparam int              CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic signed [DUR_W:0] TOL_S = (DUR_W + 1)'(TOL);

    logic [NOTAS-1:0] db_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NOTAS; gi++) begin : g_tecla
            logic             sync1_reg;
            logic             sync2_reg;
            logic             db_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Counter runs only while the synchronised key disagrees with the debounced one.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= botoes[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != db_reg) begin
                        if (cnt_reg == CNT_MAX) begin
                            db_reg  <= sync2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign db_vec[gi] = db_reg;
        end
    endgenerate

    logic       any_db;
    logic       multi_db;
    logic [3:0] code_enc;

    assign any_db   = |db_vec;
    assign multi_db = |(db_vec & (db_vec - NOTAS'(1)));

    always_comb begin
        code_enc = 4'd0;
        for (int i = 0; i < NOTAS; i++) begin
            if (db_vec[i]) code_enc = 4'(i + 1);
        end
        if (multi_db) code_enc = 4'd0;
    end

    logic [1:0]       state_reg, state_next;
    logic [DUR_W-1:0] tick_cnt_reg, tick_cnt_next, tick_cnt_inc;
    logic             troca_reg, troca_next;
    logic [3:0]       codigo_reg, codigo_next;
    logic [DUR_W-1:0] duracao_reg, duracao_next;
    logic             correta_reg, correta_next;
    logic             tempo_reg, tempo_next;
    logic             feita_reg;
    logic signed [DUR_W:0] dur_diff, dur_abs;
    logic             tempo_ok;

    // The release-cycle tick counts, so the result uses the incremented value.
    assign tick_cnt_inc = (tick_metro && (tick_cnt_reg != '1)) ? tick_cnt_reg + DUR_W'(1) : tick_cnt_reg;
    assign dur_diff     = $signed({1'b0, tick_cnt_inc}) - $signed({1'b0, duracao_esperada});
    assign dur_abs      = dur_diff[DUR_W] ? -dur_diff : dur_diff;
    assign tempo_ok     = (dur_abs <= TOL_S);

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        troca_next    = troca_reg;
        codigo_next   = codigo_reg;
        duracao_next  = duracao_reg;
        correta_next  = correta_reg;
        tempo_next    = tempo_reg;
        if (zera) begin
            tick_cnt_next = '0;
            troca_next    = 1'b0;
            codigo_next   = 4'd0;
            duracao_next  = '0;
            correta_next  = 1'b0;
            tempo_next    = 1'b0;
            state_next    = any_db ? ESPERA_SOLTAR : OCIOSO;
        end else begin
            case (state_reg)
                OCIOSO: begin
                    if (any_db) begin
                        state_next    = PRESSIONADO;
                        codigo_next   = code_enc;
                        tick_cnt_next = '0;
                        troca_next    = 1'b0;
                    end
                end
                PRESSIONADO: begin
                    tick_cnt_next = tick_cnt_inc;
                    if (any_db) begin
                        if (code_enc != codigo_reg) troca_next = 1'b1;
                    end else begin
                        state_next   = OCIOSO;
                        correta_next = (codigo_reg != 4'd0) && !troca_reg && (codigo_reg == nota_esperada);
                        tempo_next   = tempo_ok;
                        duracao_next = tick_cnt_inc;
                    end
                end
                ESPERA_SOLTAR: begin
                    if (!any_db) state_next = OCIOSO;
                end
                default: state_next = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= OCIOSO;
            tick_cnt_reg <= '0;
            troca_reg    <= 1'b0;
            codigo_reg   <= 4'd0;
            duracao_reg  <= '0;
            correta_reg  <= 1'b0;
            tempo_reg    <= 1'b0;
            feita_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            troca_reg    <= troca_next;
            codigo_reg   <= codigo_next;
            duracao_reg  <= duracao_next;
            correta_reg  <= correta_next;
            tempo_reg    <= tempo_next;
            feita_reg    <= (state_next == PRESSIONADO);
        end
    end

    assign nota_feita     = feita_reg;
    assign nota_correta   = correta_reg;
    assign tempo_correto  = tempo_reg;
    assign nota_codigo    = codigo_reg;
    assign duracao_medida = duracao_reg;
    assign db_estado      = state_reg;

endmodule

// File: tb/tb_detector_nota.sv
// Scoreboard bench for detector_nota: stimulus queues expected results, a monitor checks
// them each time nota_feita falls.
module tb_detector_nota;

    localparam int NOTAS = 12, DEBOUNCE = 4, DUR_W = 4, TOL = 1;

    logic             clock = 1'b0;
    logic             reset;
    logic [NOTAS-1:0] botoes;
    logic             tick_metro;
    logic             zera;
    logic [3:0]       nota_esperada;
    logic [DUR_W-1:0] duracao_esperada;
    logic             nota_feita, nota_correta, tempo_correto;
    logic [3:0]       nota_codigo;
    logic [DUR_W-1:0] duracao_medida;
    logic [1:0]       db_estado;

    always #5 clock = ~clock;

    detector_nota #(.NOTAS(NOTAS), .DEBOUNCE(DEBOUNCE), .DUR_W(DUR_W), .TOL(TOL)) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .tick_metro(tick_metro), .zera(zera),
        .nota_esperada(nota_esperada), .duracao_esperada(duracao_esperada),
        .nota_feita(nota_feita), .nota_correta(nota_correta), .tempo_correto(tempo_correto),
        .nota_codigo(nota_codigo), .duracao_medida(duracao_medida), .db_estado(db_estado)
    );

    typedef struct {
        int codigo;
        int dur;
        int correta;
        int tempo;
        int estado;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_feita = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input int codigo, input int dur, input int correta, input int tempo, input int estado);
        exp_t e;
        e.codigo = codigo; e.dur = dur; e.correta = correta; e.tempo = tempo; e.estado = estado;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press(input logic [NOTAS-1:0] mask, input int nticks);
        int n;
        botoes = mask;
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (!nota_feita && n < 20);
        check("press_latency", n, 7);
        for (int i = 0; i < nticks; i++) begin
            tick_metro = 1'b1;
            cycles(1);
            tick_metro = 1'b0;
            cycles(1);
        end
    endtask

    task automatic release_keys();
        int n;
        botoes = '0;
        n = 0;
        do begin
            cycles(1);
            n++;
        end while (nota_feita && n < 20);
        check("release_latency", n, 7);
        cycles(2);
    endtask

    // Monitor: a falling nota_feita marks a completed (or cleared) press.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            prev_feita = 1'b0;
        end else begin
            if (prev_feita && !nota_feita) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("result codigo=%0d duracao=%0d correta=%0d tempo=%0d estado=%0d",
                             nota_codigo, duracao_medida, nota_correta, tempo_correto, db_estado);
                    check("nota_codigo", nota_codigo, e.codigo);
                    check("duracao_medida", duracao_medida, e.dur);
                    check("nota_correta", nota_correta, e.correta);
                    check("tempo_correto", tempo_correto, e.tempo);
                    check("db_estado", db_estado, e.estado);
                end
            end
            prev_feita = nota_feita;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; botoes = '0; tick_metro = 1'b0; zera = 1'b0;
        nota_esperada = 4'd0; duracao_esperada = '0;
        cycles(3);
        check("rst_feita", nota_feita, 0);
        check("rst_correta", nota_correta, 0);
        check("rst_tempo", tempo_correto, 0);
        check("rst_codigo", nota_codigo, 0);
        check("rst_duracao", duracao_medida, 0);
        check("rst_estado", db_estado, 0);
        reset = 1'b0;
        cycles(2);

        // Clean press of key 3 with varying tick counts against expected duration 5
        nota_esperada = 4'd3; duracao_esperada = 4'd5;
        push(3, 5, 1, 1, 0); press(12'h004, 5); release_keys();
        push(3, 7, 1, 0, 0); press(12'h004, 7); release_keys();
        push(3, 4, 1, 1, 0); press(12'h004, 4); release_keys();
        push(3, 6, 1, 1, 0); press(12'h004, 6); release_keys();
        push(3, 3, 1, 0, 0); press(12'h004, 3); release_keys();
        nota_esperada = 4'd4;
        push(3, 5, 0, 1, 0); press(12'h004, 5); release_keys();

        // Bouncing key 1 never produces a press
        nota_esperada = 4'd1; duracao_esperada = 4'd0;
        for (int c = 0; c < 20; c++) begin
            botoes = (((c / 2) % 2) == 0) ? 12'h001 : 12'h000;
            cycles(1);
            check("bounce_no_press", nota_feita, 0);
        end
        botoes = '0;
        for (int c = 0; c < 10; c++) begin
            cycles(1);
            check("bounce_settle", nota_feita, 0);
        end
        push(1, 0, 1, 1, 0); press(12'h001, 0); release_keys();

        // Chord of keys 1 and 5 is invalid
        nota_esperada = 4'd1; duracao_esperada = 4'd2;
        push(0, 2, 0, 1, 0); press(12'h011, 2); release_keys();

        // Slide from key 2 to key 4 sets troca
        nota_esperada = 4'd2; duracao_esperada = 4'd3;
        push(2, 3, 0, 1, 0); press(12'h002, 3);
        botoes = 12'h00A; cycles(10);
        botoes = 12'h008; cycles(10);
        release_keys();

        // Duration saturates at 15
        nota_esperada = 4'd3; duracao_esperada = 4'd15;
        push(3, 15, 1, 1, 0); press(12'h004, 20); release_keys();

        // Asynchronous reset during a press of key 5
        press(12'h010, 2);
        reset = 1'b1;
        #1;
        check("arst_feita", nota_feita, 0);
        check("arst_correta", nota_correta, 0);
        check("arst_tempo", tempo_correto, 0);
        check("arst_codigo", nota_codigo, 0);
        check("arst_duracao", duracao_medida, 0);
        check("arst_estado", db_estado, 0);
        botoes = '0;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("post_reset_idle", nota_feita, 0);

        // zera with key held: waits for release, no result
        nota_esperada = 4'd3; duracao_esperada = 4'd2;
        press(12'h004, 2);
        push(0, 0, 0, 0, 2);
        zera = 1'b1;
        cycles(1);
        zera = 1'b0;
        check("zera_estado", db_estado, 2);
        check("zera_feita", nota_feita, 0);
        cycles(3);
        botoes = '0;
        cycles(10);
        check("zera_rel_estado", db_estado, 0);
        check("zera_rel_correta", nota_correta, 0);
        check("zera_rel_tempo", tempo_correto, 0);
        check("zera_rel_codigo", nota_codigo, 0);
        check("zera_rel_duracao", duracao_medida, 0);
        check("zera_rel_feita", nota_feita, 0);

        cycles(5);
        check("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
